cam_frame_sequencer: RTL and testbench
======================================

Name: cam_frame_sequencer

Overview:
- N-camera frame capture sequencer: selects one camera at a time, waits for that camera's frame start, and writes exactly one WIDTH x HEIGHT frame of decoded pixels into that camera's region of a shared frame memory.
- Advances round-robin or holds one camera, then drives the camera select for the next capture.
- Also generates the registered display-side read address for the most recently completed frame.
- Sits between the raw8 pixel decoder output and the frame buffer; replaces the fixed two-camera switching logic.

Parameters:
- NUM_CAMS, 2, number of camera channels (1..8).
- WIDTH, 640, pixels per line.
- HEIGHT, 480, lines per frame.
- DATA_W, 8, pixel width.
- ADDR_W, 20, memory address width; must satisfy 2^ADDR_W >= NUM_CAMS*WIDTH*HEIGHT.
- XY_W, 10, width of display x/y coordinates.
- SETTLE_CYCLES, 16, idle cycles after a camera switch before a frame start is accepted.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- mode  in  1  0 = round-robin over all cameras; 1 = fixed camera.
- fixed_cam  in  CAM_W  camera used when mode=1; CAM_W = max(1, clog2(NUM_CAMS)).
- cam_sel  out  CAM_W  camera currently routed to the decoder.
- pix_data  in  DATA_W  decoded pixel.
- pix_valid  in  1  one-cycle strobe per pixel.
- frame_start  in  1  start-of-frame pulse from the selected camera.
- frame_end  in  1  end-of-frame pulse from the selected camera.
- wr_en  out  1  memory write strobe.
- wr_addr  out  ADDR_W  memory write address.
- wr_data  out  DATA_W  memory write data.
- frame_done  out  1  one-cycle pulse when a full frame has been stored.
- frame_short  out  1  one-cycle pulse when frame_end or frame_start arrives before WIDTH*HEIGHT pixels.
- disp_cam  out  CAM_W  camera whose last complete frame is displayed.
- rd_x, rd_y  in  XY_W  display coordinates.
- rd_addr  out  ADDR_W  memory read address.
- rd_valid  out  1  1 when (rd_x, rd_y) is inside the frame.

Behaviour:
- Reset values: all outputs 0.
  - cam_sel = 0 in round-robin mode; in fixed mode cam_sel takes fixed_cam on the first SWITCH.
  - State = SWITCH; settle counter = 0.
- FRAME = WIDTH*HEIGHT. Region base for camera c = c*FRAME.
- State SWITCH:
  - Count SETTLE_CYCLES cycles, ignoring all inputs, then go to WAIT_SOF.
- State WAIT_SOF:
  - pix_valid and frame_end are ignored.
  - On frame_start: pixel count <= 0, go to CAPTURE.
  - If pix_valid is high in the same cycle as frame_start, that pixel is pixel 0: written at base, count <= 1.
- State CAPTURE, on pix_valid:
  - wr_en=1, wr_addr = base(cam_sel)+count, wr_data = pix_data, all registered with 1-cycle latency; count increments.
- Frame complete: when the write of pixel FRAME-1 is issued:
  - frame_done pulses in the same cycle as that wr_en.
  - disp_cam <= cam_sel.
  - Go to NEXT.
  - Pixels beyond FRAME are never written.
- frame_end in CAPTURE with count < FRAME:
  - frame_short pulses; go to WAIT_SOF on the same camera; disp_cam unchanged.
- frame_start in CAPTURE (any count):
  - frame_short pulses; count restarts at 0 (or 1 if pix_valid in the same cycle); stay in CAPTURE.
- State NEXT (1 cycle):
  - mode=0: cam_sel <= (cam_sel == NUM_CAMS-1) ? 0 : cam_sel+1.
  - mode=1: cam_sel <= fixed_cam, clamped to NUM_CAMS-1.
  - If cam_sel changed, go to SWITCH; otherwise go to WAIT_SOF directly.
- mode or fixed_cam changing mid-capture takes effect only at NEXT.
- Read path, 1-cycle latency:
  - rd_addr <= base(disp_cam) + rd_y*WIDTH + rd_x.
  - rd_valid <= (rd_x < WIDTH) && (rd_y < HEIGHT).
  - When rd_valid=0, rd_addr = base(disp_cam).
- Arithmetic is unsigned, computed at ADDR_W bits; no wrap is possible under the ADDR_W constraint.
- Reset assertion mid-frame aborts immediately; no partial frame_done.

Decomposition:
- Shared package cam_pkg:
  - state enum {SWITCH, WAIT_SOF, CAPTURE, NEXT};
  - MODE_RR=0, MODE_FIXED=1;
  - clog2 function.
- One sub-module: frame_addr_gen (base multiply plus y*WIDTH+x, registered), instantiated for the read path.
  - The write path uses an incrementing base+count register instead.

Test Plan:
- NUM_CAMS=2, WIDTH=4, HEIGHT=2, SETTLE_CYCLES=2, mode=0; frame_start, then 8 pix_valid with data 1..8 -> wr_addr 0..7 with data 1..8; frame_done on the 8th write; disp_cam=0; cam_sel=1 after NEXT; next frame writes addr 8..15.
- frame_start plus pix_valid in the same cycle (data 0xAA) -> write at addr base+0 = 0xAA; total of 8 writes.
- frame_end after 5 pixels -> frame_short pulse; no frame_done; cam_sel unchanged; next full frame rewrites addr 0..7.
- 10 pixels after frame_start -> exactly 8 writes; extra 2 ignored; no write to addr 8 from cam 0.
- mode=1, fixed_cam=1 -> after NEXT, cam_sel stays 1 with no SWITCH delay on repeat frames; fixed_cam=3 is clamped to 1.
- disp_cam=1, rd_x=3, rd_y=1 -> rd_addr=15, rd_valid=1 one cycle later; rd_x=4 -> rd_valid=0, rd_addr=8.

Source files
------------

// File: rtl/cam_pkg.sv
// Shared types and helpers for the multi-camera frame capture sequencer.
package cam_pkg;

   typedef enum logic [1:0] {
      SWITCH   = 2'd0,
      WAIT_SOF = 2'd1,
      CAPTURE  = 2'd2,
      NEXT     = 2'd3
   } state_t;

   localparam logic MODE_RR    = 1'b0;
   localparam logic MODE_FIXED = 1'b1;

   // Ceiling log2 for elaboration-time width calculations.
   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) result = i + 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/frame_addr_gen.sv
// Registered frame-memory address generator: region base of a camera plus
// the linear offset y*WIDTH+x, with an in-frame flag.
module frame_addr_gen #(
   parameter int CAM_W  = 1,
   parameter int WIDTH  = 640,
   parameter int HEIGHT = 480,
   parameter int XY_W   = 10,
   parameter int ADDR_W = 20
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [CAM_W-1:0]  cam,
   input  logic [XY_W-1:0]   x,
   input  logic [XY_W-1:0]   y,
   output logic [ADDR_W-1:0] addr,
   output logic              valid
);

   localparam logic [ADDR_W-1:0] FRAME_A = ADDR_W'(WIDTH * HEIGHT);
   localparam logic [ADDR_W-1:0] WIDTH_A = ADDR_W'(WIDTH);

   logic [ADDR_W-1:0] base;
   logic [ADDR_W-1:0] offset;
   logic              in_frame;
   logic [ADDR_W-1:0] addr_reg, addr_next;
   logic              valid_reg, valid_next;

   always_comb begin
      base       = ADDR_W'(cam) * FRAME_A;
      offset     = ADDR_W'(y) * WIDTH_A + ADDR_W'(x);
      in_frame   = (32'(x) < 32'(WIDTH)) && (32'(y) < 32'(HEIGHT));
      // Out-of-frame coordinates park the address on the region base.
      addr_next  = in_frame ? (base + offset) : base;
      valid_next = in_frame;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_reg  <= '0;
         valid_reg <= 1'b0;
      end else begin
         addr_reg  <= addr_next;
         valid_reg <= valid_next;
      end
   end

   assign addr  = addr_reg;
   assign valid = valid_reg;

endmodule

// File: rtl/cam_frame_sequencer.sv
// N-camera frame capture sequencer: selects a camera, captures exactly one
// WIDTH x HEIGHT frame into its memory region, then advances or holds.
module cam_frame_sequencer
   import cam_pkg::*;
#(
   parameter int NUM_CAMS      = 2,
   parameter int WIDTH         = 640,
   parameter int HEIGHT        = 480,
   parameter int DATA_W        = 8,
   parameter int ADDR_W        = 20,
   parameter int XY_W          = 10,
   parameter int SETTLE_CYCLES = 16,
   localparam int CAM_W        = (NUM_CAMS > 1) ? clog2(NUM_CAMS) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              mode,
   input  logic [CAM_W-1:0]  fixed_cam,
   output logic [CAM_W-1:0]  cam_sel,
   input  logic [DATA_W-1:0] pix_data,
   input  logic              pix_valid,
   input  logic              frame_start,
   input  logic              frame_end,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic              frame_done,
   output logic              frame_short,
   output logic [CAM_W-1:0]  disp_cam,
   input  logic [XY_W-1:0]   rd_x,
   input  logic [XY_W-1:0]   rd_y,
   output logic [ADDR_W-1:0] rd_addr,
   output logic              rd_valid
);

   localparam int FRAME = WIDTH * HEIGHT;
   localparam int SET_W = (SETTLE_CYCLES > 0) ? clog2(SETTLE_CYCLES + 1) : 1;
   localparam logic [ADDR_W-1:0] FRAME_A  = ADDR_W'(FRAME);
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME - 1);
   localparam logic [CAM_W-1:0]  MAX_CAM  = CAM_W'(NUM_CAMS - 1);

   state_t            state_reg, state_next;
   logic [SET_W-1:0]  settle_reg, settle_next;
   logic              boot_reg, boot_next;
   logic [CAM_W-1:0]  cam_sel_reg, cam_sel_next;
   logic [CAM_W-1:0]  disp_cam_reg, disp_cam_next;
   logic [ADDR_W-1:0] count_reg, count_next;
   logic [ADDR_W-1:0] ptr_reg, ptr_next;
   logic              wr_en_reg, wr_en_next;
   logic [ADDR_W-1:0] wr_addr_reg, wr_addr_next;
   logic [DATA_W-1:0] wr_data_reg, wr_data_next;
   logic              frame_done_reg, frame_done_next;
   logic              frame_short_reg, frame_short_next;

   logic              restart;
   logic              store;
   logic              end_seen;
   logic [ADDR_W-1:0] store_addr;
   logic [ADDR_W-1:0] store_idx;
   logic [ADDR_W-1:0] cam_base;
   logic [CAM_W-1:0]  rr_cam;
   logic [CAM_W-1:0]  clamped_cam;

   always_comb begin
      cam_base    = ADDR_W'(cam_sel_reg) * FRAME_A;
      rr_cam      = (cam_sel_reg == MAX_CAM) ? '0 : cam_sel_reg + 1'b1;
      // Widened compare so the clamp stays meaningful when CAM_W is exact.
      clamped_cam = ({1'b0, fixed_cam} > {1'b0, MAX_CAM}) ? MAX_CAM : fixed_cam;
   end

   always_comb begin
      state_next       = state_reg;
      settle_next      = settle_reg;
      boot_next        = boot_reg;
      cam_sel_next     = cam_sel_reg;
      disp_cam_next    = disp_cam_reg;
      count_next       = count_reg;
      ptr_next         = ptr_reg;
      wr_en_next       = 1'b0;
      wr_addr_next     = wr_addr_reg;
      wr_data_next     = wr_data_reg;
      frame_done_next  = 1'b0;
      frame_short_next = 1'b0;
      restart          = 1'b0;
      store            = 1'b0;
      end_seen         = 1'b0;
      store_addr       = ptr_reg;
      store_idx        = count_reg;

      case (state_reg)
         SWITCH: begin
            if (boot_reg) begin
               boot_next = 1'b0;
               if (mode == MODE_FIXED) cam_sel_next = clamped_cam;
            end
            if (int'(settle_reg) + 1 >= SETTLE_CYCLES) begin
               settle_next = '0;
               state_next  = WAIT_SOF;
            end else begin
               settle_next = settle_reg + 1'b1;
            end
         end
         WAIT_SOF: begin
            restart = frame_start;
         end
         CAPTURE: begin
            if (frame_start) begin
               restart          = 1'b1;
               frame_short_next = 1'b1;
            end else begin
               store    = pix_valid;
               end_seen = frame_end;
            end
         end
         NEXT: begin
            cam_sel_next = (mode == MODE_RR) ? rr_cam : clamped_cam;
            settle_next  = '0;
            state_next   = (cam_sel_next != cam_sel_reg) ? SWITCH : WAIT_SOF;
         end
         default: begin
            state_next = SWITCH;
         end
      endcase

      // A frame start may carry pixel 0 in the same cycle.
      if (restart) begin
         state_next = CAPTURE;
         count_next = '0;
         ptr_next   = cam_base;
         store      = pix_valid;
         store_addr = cam_base;
         store_idx  = '0;
      end

      if (store) begin
         wr_en_next   = 1'b1;
         wr_addr_next = store_addr;
         wr_data_next = pix_data;
         count_next   = store_idx + 1'b1;
         ptr_next     = store_addr + 1'b1;
         if (store_idx == LAST_IDX) begin
            frame_done_next = 1'b1;
            disp_cam_next   = cam_sel_reg;
            state_next      = NEXT;
         end
      end

      // End-of-frame only counts as short if this cycle did not complete it.
      if (end_seen && state_next == CAPTURE) begin
         frame_short_next = 1'b1;
         state_next       = WAIT_SOF;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg       <= SWITCH;
         settle_reg      <= '0;
         boot_reg        <= 1'b1;
         cam_sel_reg     <= '0;
         disp_cam_reg    <= '0;
         count_reg       <= '0;
         ptr_reg         <= '0;
         wr_en_reg       <= 1'b0;
         wr_addr_reg     <= '0;
         wr_data_reg     <= '0;
         frame_done_reg  <= 1'b0;
         frame_short_reg <= 1'b0;
      end else begin
         state_reg       <= state_next;
         settle_reg      <= settle_next;
         boot_reg        <= boot_next;
         cam_sel_reg     <= cam_sel_next;
         disp_cam_reg    <= disp_cam_next;
         count_reg       <= count_next;
         ptr_reg         <= ptr_next;
         wr_en_reg       <= wr_en_next;
         wr_addr_reg     <= wr_addr_next;
         wr_data_reg     <= wr_data_next;
         frame_done_reg  <= frame_done_next;
         frame_short_reg <= frame_short_next;
      end
   end

   assign cam_sel     = cam_sel_reg;
   assign disp_cam    = disp_cam_reg;
   assign wr_en       = wr_en_reg;
   assign wr_addr     = wr_addr_reg;
   assign wr_data     = wr_data_reg;
   assign frame_done  = frame_done_reg;
   assign frame_short = frame_short_reg;

   frame_addr_gen #(
      .CAM_W  (CAM_W),
      .WIDTH  (WIDTH),
      .HEIGHT (HEIGHT),
      .XY_W   (XY_W),
      .ADDR_W (ADDR_W)
   ) u_rd_addr (
      .clk   (clk),
      .rst_n (rst_n),
      .cam   (disp_cam_reg),
      .x     (rd_x),
      .y     (rd_y),
      .addr  (rd_addr),
      .valid (rd_valid)
   );

endmodule

// File: tb/tb_cam_frame_sequencer.sv
// Directed bench for cam_frame_sequencer: 2 cameras, 4x2 frames, settle of 2.
module tb_cam_frame_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        mode;
   logic [0:0]  fixed_cam;
   logic [0:0]  cam_sel;
   logic [7:0]  pix_data;
   logic        pix_valid;
   logic        frame_start;
   logic        frame_end;
   logic        wr_en;
   logic [19:0] wr_addr;
   logic [7:0]  wr_data;
   logic        frame_done;
   logic        frame_short;
   logic [0:0]  disp_cam;
   logic [9:0]  rd_x;
   logic [9:0]  rd_y;
   logic [19:0] rd_addr;
   logic        rd_valid;

   int checks = 0;
   int errors = 0;

   cam_frame_sequencer #(
      .NUM_CAMS      (2),
      .WIDTH         (4),
      .HEIGHT        (2),
      .DATA_W        (8),
      .ADDR_W        (20),
      .XY_W          (10),
      .SETTLE_CYCLES (2)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .mode        (mode),
      .fixed_cam   (fixed_cam),
      .cam_sel     (cam_sel),
      .pix_data    (pix_data),
      .pix_valid   (pix_valid),
      .frame_start (frame_start),
      .frame_end   (frame_end),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .frame_done  (frame_done),
      .frame_short (frame_short),
      .disp_cam    (disp_cam),
      .rd_x        (rd_x),
      .rd_y        (rd_y),
      .rd_addr     (rd_addr),
      .rd_valid    (rd_valid)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one pixel for one clock and check the registered write it causes.
   task automatic pix(input string tag, input logic [7:0] d, input logic we,
                      input logic [19:0] a, input logic done);
      pix_valid = 1'b1;
      pix_data  = d;
      tick();
      pix_valid = 1'b0;
      $display("[%0t] %s data=%02h -> wr_en=%0d wr_addr=%0d wr_data=%02h done=%0d",
               $time, tag, d, wr_en, wr_addr, wr_data, frame_done);
      chk({tag, " wr_en"}, 32'(wr_en), 32'(we));
      if (we) begin
         chk({tag, " wr_addr"}, 32'(wr_addr), 32'(a));
         chk({tag, " wr_data"}, 32'(wr_data), 32'(d));
      end
      chk({tag, " frame_done"}, 32'(frame_done), 32'(done));
   endtask

   task automatic rd(input logic [9:0] x, input logic [9:0] y,
                     input logic [19:0] a, input logic v);
      rd_x = x;
      rd_y = y;
      tick();
      $display("[%0t] read x=%0d y=%0d -> rd_addr=%0d rd_valid=%0d", $time, x, y, rd_addr, rd_valid);
      chk("rd_addr", 32'(rd_addr), 32'(a));
      chk("rd_valid", 32'(rd_valid), 32'(v));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0; mode = 1'b0; fixed_cam = 1'b0;
      pix_data = 8'h00; pix_valid = 1'b0; frame_start = 1'b0; frame_end = 1'b0;
      rd_x = '0; rd_y = '0;
      repeat (2) tick();
      $display("[%0t] reset state", $time);
      chk("reset cam_sel", 32'(cam_sel), 32'd0);
      chk("reset wr_en", 32'(wr_en), 32'd0);
      chk("reset frame_done", 32'(frame_done), 32'd0);
      chk("reset frame_short", 32'(frame_short), 32'd0);
      chk("reset disp_cam", 32'(disp_cam), 32'd0);
      chk("reset rd_addr", 32'(rd_addr), 32'd0);
      chk("reset rd_valid", 32'(rd_valid), 32'd0);

      rst_n = 1'b1;
      repeat (3) tick();
      chk("boot cam_sel", 32'(cam_sel), 32'd0);

      // Frame 1, camera 0: addresses 0..7
      frame_start = 1'b1; tick(); frame_start = 1'b0;
      chk("f1 sof wr_en", 32'(wr_en), 32'd0);
      for (int k = 1; k <= 8; k++) pix("f1", 8'(k), 1'b1, 20'(k - 1), k == 8);
      chk("f1 disp_cam", 32'(disp_cam), 32'd0);
      tick();
      chk("f1 next cam_sel", 32'(cam_sel), 32'd1);
      chk("f1 next wr_en", 32'(wr_en), 32'd0);
      chk("f1 next frame_done", 32'(frame_done), 32'd0);

      // A frame start during the settle window must be ignored
      frame_start = 1'b1; tick(); frame_start = 1'b0;
      tick();

      // Frame 2, camera 1: start and first pixel together
      frame_start = 1'b1;
      pix("f2 sof", 8'hAA, 1'b1, 20'd8, 1'b0);
      frame_start = 1'b0;
      chk("f2 frame_short", 32'(frame_short), 32'd0);
      for (int k = 2; k <= 8; k++) pix("f2", 8'(k), 1'b1, 20'(8 + k - 1), k == 8);
      chk("f2 disp_cam", 32'(disp_cam), 32'd1);
      tick();
      chk("f2 next cam_sel", 32'(cam_sel), 32'd0);

      // Display reads against camera 1's region
      rd(10'd3, 10'd1, 20'd15, 1'b1);
      rd(10'd4, 10'd1, 20'd8,  1'b0);
      rd(10'd0, 10'd2, 20'd8,  1'b0);
      rd(10'd0, 10'd0, 20'd8,  1'b1);
      rd(10'd2, 10'd1, 20'd14, 1'b1);

      // Frame 3, camera 0: ends after 5 pixels
      frame_start = 1'b1; tick(); frame_start = 1'b0;
      for (int k = 0; k < 5; k++) pix("f3", 8'(8'h10 + k), 1'b1, 20'(k), 1'b0);
      frame_end = 1'b1; tick(); frame_end = 1'b0;
      $display("[%0t] f3 frame_end -> frame_short=%0d", $time, frame_short);
      chk("f3 frame_short", 32'(frame_short), 32'd1);
      chk("f3 frame_done", 32'(frame_done), 32'd0);
      chk("f3 wr_en", 32'(wr_en), 32'd0);
      tick();
      chk("f3 short pulse width", 32'(frame_short), 32'd0);
      chk("f3 cam_sel", 32'(cam_sel), 32'd0);

      // Frame 4, camera 0: 10 pixels offered, only 8 written
      frame_start = 1'b1; tick(); frame_start = 1'b0;
      for (int k = 0; k < 10; k++) begin
         if (k < 8) pix("f4", 8'(8'h20 + k), 1'b1, 20'(k), k == 7);
         else       pix("f4 extra", 8'(8'h20 + k), 1'b0, 20'd0, 1'b0);
      end
      chk("f4 disp_cam", 32'(disp_cam), 32'd0);
      chk("f4 cam_sel", 32'(cam_sel), 32'd1);
      tick();

      // Frame 5, camera 1: restarted by a second frame start
      frame_start = 1'b1; tick(); frame_start = 1'b0;
      for (int k = 0; k < 3; k++) pix("f5a", 8'(8'h30 + k), 1'b1, 20'(8 + k), 1'b0);
      frame_start = 1'b1; tick(); frame_start = 1'b0;
      $display("[%0t] f5 restart -> frame_short=%0d", $time, frame_short);
      chk("f5 restart frame_short", 32'(frame_short), 32'd1);
      chk("f5 restart wr_en", 32'(wr_en), 32'd0);
      mode = 1'b1; fixed_cam = 1'b1;
      for (int k = 0; k < 8; k++) pix("f5", 8'(8'h40 + k), 1'b1, 20'(8 + k), k == 7);
      chk("f5 disp_cam", 32'(disp_cam), 32'd1);
      tick();
      chk("f5 fixed cam_sel", 32'(cam_sel), 32'd1);

      // Frame 6: fixed mode on the same camera, no settle delay
      frame_start = 1'b1; tick(); frame_start = 1'b0;
      for (int k = 0; k < 8; k++) pix("f6", 8'(8'h50 + k), 1'b1, 20'(8 + k), k == 7);
      fixed_cam = 1'b0;
      tick();
      chk("f6 fixed cam_sel", 32'(cam_sel), 32'd0);
      repeat (2) tick();

      // Reset mid-frame aborts immediately
      frame_start = 1'b1; tick(); frame_start = 1'b0;
      for (int k = 0; k < 3; k++) pix("f7", 8'(8'h60 + k), 1'b1, 20'(k), 1'b0);
      pix_valid = 1'b1; pix_data = 8'h99;
      rst_n = 1'b0;
      #1;
      $display("[%0t] mid-frame reset -> wr_en=%0d cam_sel=%0d disp_cam=%0d", $time, wr_en, cam_sel, disp_cam);
      chk("abort wr_en", 32'(wr_en), 32'd0);
      chk("abort cam_sel", 32'(cam_sel), 32'd0);
      chk("abort disp_cam", 32'(disp_cam), 32'd0);
      chk("abort rd_valid", 32'(rd_valid), 32'd0);
      tick();
      pix_valid = 1'b0;
      chk("abort held wr_en", 32'(wr_en), 32'd0);
      chk("abort held frame_done", 32'(frame_done), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
